round_manager: RTL
==================

# round_manager

Parametrised successor to the game's round/score bookkeeping. Consumes one-cycle `leave` events from the movement/firing logic (`shot` / `escape` qualifiers) and maintains the per-round bird mask, the hit/miss counters, the round number, a saturating score and the game-over/win status. It also produces a BCD copy of the score for the seven-segment displays through a sequential converter, so no `/` or `%` operators are needed. Everything is synchronous to `clk`, with no event-edge-triggered state.

## Interface
- `BIRDS_PER_ROUND`, default 10: birds per round; bird-mask width.
- `PASS_HITS`, default 5: minimum hits needed to clear a round.
- `MAX_ROUNDS`, default 16: number of rounds; clearing the last one is a win.
- `HIT_POINTS`, default 50: points added per hit.
- `ESCAPE_PENALTY`, default 10: points removed per escape.
- `SCORE_DIGITS`, default 4: BCD digits. `SCORE_W = $clog2(10**SCORE_DIGITS)`.
- `clk` (in, 1): system clock, CLOCK_50 domain.
- `reset_n` (in, 1): asynchronous, active-low reset.
- `start` (in, 1): one-cycle pulse. Starts a game from IDLE or OVER.
- `leave` (in, 1): one-cycle pulse. The current bird's episode has ended.
- `shot` (in, 1): qualifier sampled with `leave`. The bird was hit.
- `escape` (in, 1): qualifier sampled with `leave`. The bird escaped.
- `bird_mask` (out, BIRDS_PER_ROUND): 1 = bird not hit. Bit i corresponds to bird i of the round.
- `hits` (out, $clog2(BIRDS_PER_ROUND+1)): hits in the current round.
- `misses` (out, same width): escapes in the current round.
- `round` (out, $clog2(MAX_ROUNDS)): zero-based round index.
- `score` (out, SCORE_W): binary score.
- `score_bcd` (out, 4*SCORE_DIGITS): BCD score, least-significant digit in [3:0].
- `bcd_valid` (out, 1): `score_bcd` matches `score`.
- `round_done` (out, 1): one-cycle pulse at the end of each round.
- `playing`, `game_over`, `win` (out, 1 each): status flags.

## Operation
- Reset values:
  - `bird_mask` = all ones.
  - `hits`, `misses`, `round`, `score` = 0.
  - `score_bcd` = 0 with `bcd_valid` = 1.
  - `round_done`, `playing`, `game_over`, `win` = 0.
  - State = IDLE.
- States:
  - IDLE → PLAY on `start`. Clears all counters and the score, and sets the mask to all ones.
  - PLAY: `leave` → UPDATE. `start` is ignored.
  - UPDATE (one cycle): applies the event, then → CHECK.
  - CHECK (one cycle):
    - If `hits + misses == BIRDS_PER_ROUND`, pulse `round_done`.
    - If `hits >= PASS_HITS` and `round != MAX_ROUNDS-1`: increment `round`, clear `hits`/`misses`, set the mask to all ones, → PLAY.
    - If `hits >= PASS_HITS` and this is the last round: → OVER with `win` = 1.
    - If `hits < PASS_HITS`: → OVER with `win` = 0.
    - If the round is not complete: → PLAY.
  - OVER: `game_over` = 1. `start` → PLAY with a full clear, including `round`, `score` and `win`.
- Event priority in UPDATE:
  - `escape` wins over `shot`: `misses` += 1; `score` = max(0, `score` − ESCAPE_PENALTY).
  - `shot` only: clear `bird_mask[hits+misses]`; `hits` += 1; `score` = min(10**SCORE_DIGITS − 1, `score` + HIT_POINTS).
  - Neither asserted: no change.
- `leave` outside PLAY is ignored. `leave` asserted in UPDATE or CHECK is dropped; the producer guarantees a spacing of at least 3 cycles.
- `playing` = 1 in PLAY, UPDATE and CHECK.
- BCD conversion:
  - Any change to `score` restarts the converter and drops `bcd_valid`.
  - `score_bcd` holds its old value until the new result is loaded. It never shows a partial result.

## Timing
- `leave` sampled in PLAY at edge t:
  - `hits`, `misses`, `bird_mask`, `score` update at t+1.
  - `round_done`, `round`, `game_over`, `win` update at t+2.
  - Ready to accept the next `leave` at t+3.
- BCD latency: `bcd_valid` rises SCORE_W+2 cycles after `score` changes (one load cycle, SCORE_W shift cycles, one output cycle).
- `start` takes effect at the next edge; `playing` = 1 one cycle after the `start` pulse.
- Reset mid-game or mid-conversion returns every output to its reset value immediately.

## Structure
- Package `duckhunt_pkg` holds:
  - the state enum `rm_state_t` (IDLE, PLAY, UPDATE, CHECK, OVER);
  - the default point constants.
- Sub-module `bcd_converter_seq`: sequential double-dabble converter with parameters W and DIGITS.
  - Ports: `clk`, `reset_n`, `load`, `bin`, `bcd`, `done`.
  - Reusable for the HEX display paths.

## Test plan
- **Reset and start:** reset, then `start`; 5 `leave`+`shot` events spaced 4 cycles apart → `hits` = 5, `bird_mask` = 10'b1111100000, `score` = 250; `score_bcd` = 0x0250 once `bcd_valid` = 1.
- **Round pass:** in one round, 5 hits then 5 escapes → `round_done` pulses once, `round` = 1, `hits` = `misses` = 0, mask all ones, `score` = 200.
- **Round fail:** 4 hits then 6 escapes → `game_over` = 1, `win` = 0; a further `leave` changes nothing; `start` clears to `round` = 0, `score` = 0.
- **Score saturation and priority:**
  - First event: `escape` from `score` = 0 → `score` stays 0.
  - `shot` and `escape` asserted together → `misses` += 1, mask unchanged.
  - Run with SCORE_DIGITS = 2 → `score` clamps at 99.
- **Win:** MAX_ROUNDS = 2; both rounds cleared with 10 hits each → `win` = 1, `game_over` = 1, `score` = 1000.
- **Reset during conversion:** assert `reset_n` low 3 cycles after a hit → all outputs at reset values; `bcd_valid` = 1 and `score_bcd` = 0 after release.

Source files
------------

// File: rtl/duckhunt_pkg.sv
// Shared types and constants for the duck-hunt round/score bookkeeping.
// Holds the round-manager state encoding and the default point values.
package duckhunt_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PLAY,
      UPDATE,
      CHECK,
      OVER
   } rm_state_t;

   localparam int DEF_HIT_POINTS     = 50;
   localparam int DEF_ESCAPE_PENALTY = 10;

   function automatic int pow10(input int n);
      int r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

endpackage

// File: rtl/round_manager_if.sv
// Event inputs and status/score outputs of the round manager.
// No handshake: inputs are one-cycle pulses, outputs are registered levels/pulses.
interface round_manager_if #(
   parameter int BIRDS_PER_ROUND = 10,
   parameter int MAX_ROUNDS      = 16,
   parameter int SCORE_DIGITS    = 4
);
   import duckhunt_pkg::*;

   localparam int CNT_W   = $clog2(BIRDS_PER_ROUND + 1);
   localparam int RND_W   = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;
   localparam int SCORE_W = $clog2(pow10(SCORE_DIGITS));

   logic                       start;
   logic                       leave;
   logic                       shot;
   logic                       escape;
   logic [BIRDS_PER_ROUND-1:0] bird_mask;
   logic [CNT_W-1:0]           hits;
   logic [CNT_W-1:0]           misses;
   logic [RND_W-1:0]           round;
   logic [SCORE_W-1:0]         score;
   logic [4*SCORE_DIGITS-1:0]  score_bcd;
   logic                       bcd_valid;
   logic                       round_done;
   logic                       playing;
   logic                       game_over;
   logic                       win;

   modport master (
      output start, leave, shot, escape,
      input  bird_mask, hits, misses, round, score, score_bcd,
             bcd_valid, round_done, playing, game_over, win
   );

   modport slave (
      input  start, leave, shot, escape,
      output bird_mask, hits, misses, round, score, score_bcd,
             bcd_valid, round_done, playing, game_over, win
   );

endinterface

// File: rtl/bcd_converter_seq.sv
// Sequential double-dabble binary-to-BCD converter; W+2 cycles from load to done.
// No backpressure: a new load aborts any conversion in flight, bcd holds the last full result.
module bcd_converter_seq #(
   parameter int W      = 14,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic [W-1:0]          bin,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  done
);

   localparam int CW = $clog2(W + 1);

   logic                busy_q;
   logic [CW-1:0]       cnt_q;
   logic [W-1:0]        bin_q;
   logic [4*DIGITS-1:0] acc_q;
   logic [4*DIGITS-1:0] bcd_q;
   logic                done_q;
   logic [4*DIGITS-1:0] acc_adj_d;

   always_comb begin
      acc_adj_d = acc_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) acc_adj_d[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         bin_q  <= '0;
         acc_q  <= '0;
         bcd_q  <= '0;
         done_q <= 1'b1;
      end else if (load) begin
         busy_q <= 1'b1;
         cnt_q  <= CW'(W);
         bin_q  <= bin;
         acc_q  <= '0;
         done_q <= 1'b0;
      end else if (busy_q) begin
         if (cnt_q != '0) begin
            {acc_q, bin_q} <= {acc_adj_d[4*DIGITS-2:0], bin_q, 1'b0};
            cnt_q          <= cnt_q - CW'(1);
         end else begin
            // Result published in one step so the display never sees a partial value
            bcd_q  <= acc_q;
            done_q <= 1'b1;
            busy_q <= 1'b0;
         end
      end
   end

   assign bcd  = bcd_q;
   assign done = done_q;

endmodule

// File: rtl/round_manager.sv
// Round/score bookkeeping FSM with saturating score and sequential BCD copy of the score.
// Latency: leave -> counters +1, round status +2, next leave accepted +3; leaves during UPDATE/CHECK are dropped.
module round_manager
   import duckhunt_pkg::*;
#(
   parameter int BIRDS_PER_ROUND = 10,
   parameter int PASS_HITS       = 5,
   parameter int MAX_ROUNDS      = 16,
   parameter int HIT_POINTS      = DEF_HIT_POINTS,
   parameter int ESCAPE_PENALTY  = DEF_ESCAPE_PENALTY,
   parameter int SCORE_DIGITS    = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   round_manager_if.slave  rm
);

   localparam int CNT_W     = $clog2(BIRDS_PER_ROUND + 1);
   localparam int RND_W     = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;
   localparam int SCORE_MAX = pow10(SCORE_DIGITS) - 1;
   localparam int SCORE_W   = $clog2(SCORE_MAX + 1);

   rm_state_t                  state_q;
   logic [BIRDS_PER_ROUND-1:0] mask_q;
   logic [CNT_W-1:0]           hits_q;
   logic [CNT_W-1:0]           misses_q;
   logic [RND_W-1:0]           round_q;
   logic [SCORE_W-1:0]         score_q;
   logic                       shot_q;
   logic                       esc_q;
   logic                       round_done_q;
   logic                       playing_q;
   logic                       game_over_q;
   logic                       win_q;
   logic                       bcd_load_q;

   logic [CNT_W:0]             total_d;
   logic                       round_full_d;
   logic                       pass_d;
   logic                       last_d;
   logic [31:0]                score_ext_d;
   logic [SCORE_W-1:0]         score_hit_d;
   logic [SCORE_W-1:0]         score_esc_d;
   logic [BIRDS_PER_ROUND-1:0] mask_hit_d;
   logic [4*SCORE_DIGITS-1:0]  bcd_w;
   logic                       bcd_done_w;

   always_comb begin
      total_d      = {1'b0, hits_q} + {1'b0, misses_q};
      round_full_d = (total_d == (CNT_W+1)'(BIRDS_PER_ROUND));
      pass_d       = (hits_q >= CNT_W'(PASS_HITS));
      last_d       = (round_q == RND_W'(MAX_ROUNDS - 1));
      score_ext_d  = 32'(score_q);
      score_hit_d  = (score_ext_d + 32'(HIT_POINTS) > 32'(SCORE_MAX)) ?
                     SCORE_W'(SCORE_MAX) : SCORE_W'(score_ext_d + 32'(HIT_POINTS));
      score_esc_d  = (score_ext_d < 32'(ESCAPE_PENALTY)) ?
                     '0 : SCORE_W'(score_ext_d - 32'(ESCAPE_PENALTY));
      // Bird index is the number of episodes already finished this round
      mask_hit_d   = mask_q & ~(BIRDS_PER_ROUND'(1) << total_d);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         mask_q       <= '1;
         hits_q       <= '0;
         misses_q     <= '0;
         round_q      <= '0;
         score_q      <= '0;
         shot_q       <= 1'b0;
         esc_q        <= 1'b0;
         round_done_q <= 1'b0;
         playing_q    <= 1'b0;
         game_over_q  <= 1'b0;
         win_q        <= 1'b0;
         bcd_load_q   <= 1'b0;
      end else begin
         round_done_q <= 1'b0;
         bcd_load_q   <= 1'b0;
         case (state_q)
            IDLE, OVER: begin
               if (rm.start) begin
                  state_q     <= PLAY;
                  mask_q      <= '1;
                  hits_q      <= '0;
                  misses_q    <= '0;
                  round_q     <= '0;
                  score_q     <= '0;
                  bcd_load_q  <= (score_q != '0);
                  playing_q   <= 1'b1;
                  game_over_q <= 1'b0;
                  win_q       <= 1'b0;
               end
            end
            PLAY: begin
               if (rm.leave) begin
                  shot_q  <= rm.shot;
                  esc_q   <= rm.escape;
                  state_q <= UPDATE;
               end
            end
            UPDATE: begin
               state_q <= CHECK;
               if (esc_q) begin
                  misses_q   <= misses_q + CNT_W'(1);
                  score_q    <= score_esc_d;
                  bcd_load_q <= (score_esc_d != score_q);
               end else if (shot_q) begin
                  mask_q     <= mask_hit_d;
                  hits_q     <= hits_q + CNT_W'(1);
                  score_q    <= score_hit_d;
                  bcd_load_q <= (score_hit_d != score_q);
               end
            end
            CHECK: begin
               if (round_full_d) begin
                  round_done_q <= 1'b1;
                  if (pass_d && !last_d) begin
                     round_q  <= round_q + RND_W'(1);
                     hits_q   <= '0;
                     misses_q <= '0;
                     mask_q   <= '1;
                     state_q  <= PLAY;
                  end else begin
                     win_q       <= pass_d;
                     game_over_q <= 1'b1;
                     playing_q   <= 1'b0;
                     state_q     <= OVER;
                  end
               end else begin
                  state_q <= PLAY;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   bcd_converter_seq #(
      .W      (SCORE_W),
      .DIGITS (SCORE_DIGITS)
   ) u_bcd (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (bcd_load_q),
      .bin     (score_q),
      .bcd     (bcd_w),
      .done    (bcd_done_w)
   );

   assign rm.bird_mask  = mask_q;
   assign rm.hits       = hits_q;
   assign rm.misses     = misses_q;
   assign rm.round      = round_q;
   assign rm.score      = score_q;
   assign rm.score_bcd  = bcd_w;
   // Valid drops in the same cycle the score changes, before the converter sees the load
   assign rm.bcd_valid  = bcd_done_w & ~bcd_load_q;
   assign rm.round_done = round_done_q;
   assign rm.playing    = playing_q;
   assign rm.game_over  = game_over_q;
   assign rm.win        = win_q;

endmodule
